block_display: RTL and testbench



---
 rtl/block_display.sv | 133 +++++++++++++
 tb/tb_block_display.sv | 164 ++++++++++++++++
 2 files changed

// File: rtl/block_display.sv
// 128x128 block-map framebuffer with a built-in 640x480 VGA scanner.
// Counters feed a 3-stage pipeline (decode, RAM read, output register) so rgb and the syncs stay aligned.
`timescale 1ns/1ps
module block_display #(
    parameter int unsigned BLK_SHIFT    = 2,
    parameter logic [5:0]  BORDER_COLOR = 6'b000011,
    parameter int unsigned H_ACTIVE     = 640,
    parameter int unsigned H_FP         = 16,
    parameter int unsigned H_SYNC       = 96,
    parameter int unsigned H_BP         = 48,
    parameter int unsigned V_ACTIVE     = 480,
    parameter int unsigned V_FP         = 10,
    parameter int unsigned V_SYNC       = 2,
    parameter int unsigned V_BP         = 33
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [13:0] block_addr,
    input  logic [5:0]  block_data,
    input  logic        block_we,
    output logic [5:0]  rgb,
    output logic        hsync_n,
    output logic        vsync_n,
    output logic        frame_tick
);

    localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_ACTIVE);
    localparam logic [9:0] V_VIS  = 10'(V_ACTIVE);
    localparam logic [9:0] H_SS   = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] H_SE   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_SS   = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] V_SE   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] MAP_W  = 10'(128 << BLK_SHIFT);

    logic [5:0]  mem [0:16383];
    logic [5:0]  rd_data_q;

    logic [9:0]  h_cnt_q, h_cnt_d;
    logic [9:0]  v_cnt_q, v_cnt_d;
    logic [13:0] s1_addr_q, s1_addr_d;
    logic        s1_vis_q, s1_vis_d, s1_map_q, s1_map_d;
    logic        s1_hs_q, s1_hs_d, s1_vs_q, s1_vs_d;
    logic        s2_vis_q, s2_vis_d, s2_map_q, s2_map_d;
    logic        s2_hs_q, s2_hs_d, s2_vs_q, s2_vs_d;
    logic [5:0]  rgb_q, rgb_d;
    logic        hsync_n_q, hsync_n_d;
    logic        vsync_n_q, vsync_n_d;
    logic        frame_tick_q, frame_tick_d;

    always_comb begin
        h_cnt_d = h_cnt_q + 10'd1;
        v_cnt_d = v_cnt_q;
        if (h_cnt_q == H_LAST) begin
            h_cnt_d = '0;
            v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 10'd1;
        end

        s1_addr_d = {v_cnt_q[BLK_SHIFT+6:BLK_SHIFT], h_cnt_q[BLK_SHIFT+6:BLK_SHIFT]};
        s1_vis_d  = (h_cnt_q < H_VIS) && (v_cnt_q < V_VIS);
        s1_map_d  = (h_cnt_q < MAP_W);
        s1_hs_d   = (h_cnt_q >= H_SS) && (h_cnt_q <= H_SE);
        s1_vs_d   = (v_cnt_q >= V_SS) && (v_cnt_q <= V_SE);

        s2_vis_d = s1_vis_q;
        s2_map_d = s1_map_q;
        s2_hs_d  = s1_hs_q;
        s2_vs_d  = s1_vs_q;

        rgb_d = '0;
        if (s2_vis_q) begin
            rgb_d = s2_map_q ? rd_data_q : BORDER_COLOR;
        end
        hsync_n_d = ~s2_hs_q;
        vsync_n_d = ~s2_vs_q;

        // frame_tick bypasses the pipeline: it marks the counters entering vertical blank
        frame_tick_d = (h_cnt_q == '0) && (v_cnt_q == V_VIS);
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            h_cnt_q      <= '0;
            v_cnt_q      <= '0;
            s1_addr_q    <= '0;
            s1_vis_q     <= 1'b0;
            s1_map_q     <= 1'b0;
            s1_hs_q      <= 1'b0;
            s1_vs_q      <= 1'b0;
            s2_vis_q     <= 1'b0;
            s2_map_q     <= 1'b0;
            s2_hs_q      <= 1'b0;
            s2_vs_q      <= 1'b0;
            rgb_q        <= '0;
            hsync_n_q    <= 1'b1;
            vsync_n_q    <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            h_cnt_q      <= h_cnt_d;
            v_cnt_q      <= v_cnt_d;
            s1_addr_q    <= s1_addr_d;
            s1_vis_q     <= s1_vis_d;
            s1_map_q     <= s1_map_d;
            s1_hs_q      <= s1_hs_d;
            s1_vs_q      <= s1_vs_d;
            s2_vis_q     <= s2_vis_d;
            s2_map_q     <= s2_map_d;
            s2_hs_q      <= s2_hs_d;
            s2_vs_q      <= s2_vs_d;
            rgb_q        <= rgb_d;
            hsync_n_q    <= hsync_n_d;
            vsync_n_q    <= vsync_n_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    // Map RAM has no reset; non-blocking read and write on one edge gives read-first collisions.
    always_ff @(posedge clk) begin
        if (block_we) begin
            mem[block_addr] <= block_data;
        end
        rd_data_q <= mem[s1_addr_q];
    end

    assign rgb        = rgb_q;
    assign hsync_n    = hsync_n_q;
    assign vsync_n    = vsync_n_q;
    assign frame_tick = frame_tick_q;

endmodule

// File: tb/tb_block_display.sv
// Directed bench for block_display; vertical timing shortened so whole frames fit in a short run.
`timescale 1ns/1ps
module tb_block_display;

    localparam int VA = 16, VF = 2, VS = 2, VB = 2;
    localparam int LINE = 800;
    localparam int FRAME = LINE * (VA + VF + VS + VB);

    localparam int S_RGB = 0, S_HS = 1, S_VS = 2, S_FT = 3, S_WE_ON = 4, S_WE_OFF = 5;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [13:0] block_addr = '0;
    logic [5:0]  block_data = '0;
    logic        block_we = 1'b0;
    logic [5:0]  rgb;
    logic        hsync_n, vsync_n, frame_tick;

    int cyc = 0;
    int n_checks = 0;
    int n_fail = 0;
    int ft_cnt = 0;
    int ft_cyc [2];

    block_display #(
        .V_ACTIVE (VA),
        .V_FP     (VF),
        .V_SYNC   (VS),
        .V_BP     (VB)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .block_addr (block_addr),
        .block_data (block_data),
        .block_we   (block_we),
        .rgb        (rgb),
        .hsync_n    (hsync_n),
        .vsync_n    (vsync_n),
        .frame_tick (frame_tick)
    );

    always #20 clk = ~clk;

    // cyc equals the counter cycle index: 0 right after the last reset edge
    always @(posedge clk) cyc <= (!rst) ? 0 : cyc + 1;

    always @(negedge clk) begin
        if (frame_tick === 1'b1) begin
            if (ft_cnt < 2) ft_cyc[ft_cnt] = cyc;
            ft_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, got, want, cyc);
        end
    endtask

    task automatic vec(input int c, input int sel, input logic [5:0] want, input string tag);
        int guard = 0;
        while (cyc < c && guard < 100000) begin
            @(negedge clk);
            guard++;
        end
        if (cyc != c) check({tag, "_cyc"}, 32'(cyc), 32'(c));
        case (sel)
            S_RGB:    check(tag, 32'(rgb), 32'(want));
            S_HS:     check(tag, 32'(hsync_n), 32'(want));
            S_VS:     check(tag, 32'(vsync_n), 32'(want));
            S_FT:     check(tag, 32'(frame_tick), 32'(want));
            S_WE_ON:  begin block_addr = 14'd10; block_data = want; block_we = 1'b1; end
            default:  block_we = 1'b0;
        endcase
    endtask

    task automatic wr(input logic [13:0] a, input logic [5:0] d);
        @(negedge clk);
        block_addr = a;
        block_data = d;
        block_we   = 1'b1;
    endtask

    initial begin
        // Fill rows 0..7 while in reset; writes must be accepted during reset.
        for (int i = 0; i < 1024; i++) wr(14'(i), 6'h00);
        wr(14'h0000, 6'b110000);
        wr(14'h0081, 6'b001100);
        wr(14'd330, 6'h2A);
        wr(14'd331, 6'h2A);
        @(negedge clk);
        block_we = 1'b0;
        @(negedge clk);
        check("rst_rgb", 32'(rgb), 32'h0);
        check("rst_hsync_n", 32'(hsync_n), 32'h1);
        check("rst_vsync_n", 32'(vsync_n), 32'h1);
        check("rst_frame_tick", 32'(frame_tick), 32'h0);
        rst = 1'b1;

        vec(3,    S_RGB, 6'h30, "px0_0");
        vec(5,    S_RGB, 6'h30, "px2_0");
        vec(7,    S_RGB, 6'h00, "px4_0");
        vec(41,   S_WE_ON, 6'h3F, "");
        vec(42,   S_WE_OFF, 6'h00, "");
        vec(43,   S_RGB, 6'h00, "coll_old");
        vec(44,   S_RGB, 6'h3F, "coll_new_same_frame");
        vec(514,  S_RGB, 6'h00, "px511_0");
        vec(515,  S_RGB, 6'h03, "border512");
        vec(642,  S_RGB, 6'h03, "border639");
        vec(643,  S_RGB, 6'h00, "hblank640");
        vec(658,  S_HS,  6'h1,  "hs_before");
        vec(659,  S_HS,  6'h0,  "hs_fall");
        vec(754,  S_HS,  6'h0,  "hs_last");
        vec(755,  S_HS,  6'h1,  "hs_rise");
        vec(LINE + 658, S_HS, 6'h1, "hs2_before");
        vec(LINE + 659, S_HS, 6'h0, "hs2_fall");
        vec(3 * LINE + 3 + 3, S_RGB, 6'h30, "px3_3");
        vec(4 * LINE + 4 + 3, S_RGB, 6'h0C, "px4_4");
        vec(5 * LINE + 512 + 3, S_RGB, 6'h03, "border_line5");
        vec(7 * LINE + 7 + 3, S_RGB, 6'h0C, "px7_7");
        vec(8 * LINE + 8 + 3, S_RGB, 6'h00, "px8_8");
        vec(VA * LINE,     S_FT, 6'h0, "ft_before");
        vec(VA * LINE + 1, S_FT, 6'h1, "ft_pulse");
        vec(VA * LINE + 2, S_FT, 6'h0, "ft_after");
        vec(VA * LINE + 3, S_RGB, 6'h00, "vblank_rgb");
        vec((VA + VF) * LINE + 2, S_VS, 6'h1, "vs_before");
        vec((VA + VF) * LINE + 3, S_VS, 6'h0, "vs_fall");
        vec((VA + VF + VS) * LINE + 2, S_VS, 6'h0, "vs_last");
        vec((VA + VF + VS) * LINE + 3, S_VS, 6'h1, "vs_rise");
        vec(FRAME + 43, S_RGB, 6'h3F, "coll_next_frame");
        vec(FRAME + VA * LINE,     S_FT, 6'h0, "ft2_before");
        vec(FRAME + VA * LINE + 1, S_FT, 6'h1, "ft2_pulse");
        vec(2 * FRAME + 10 * LINE + 300, S_RGB, 6'h2A, "pre_reset_px");

        // Mid-frame reset with counters at h=300, v=10
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("mid_rst_rgb", 32'(rgb), 32'h0);
            check("mid_rst_hsync_n", 32'(hsync_n), 32'h1);
            check("mid_rst_vsync_n", 32'(vsync_n), 32'h1);
            check("mid_rst_ft", 32'(frame_tick), 32'h0);
        end
        rst = 1'b1;
        vec(1,   S_RGB, 6'h00, "post_rst_rgb1");
        vec(1,   S_HS,  6'h1,  "post_rst_hs1");
        vec(2,   S_RGB, 6'h00, "post_rst_rgb2");
        vec(2,   S_VS,  6'h1,  "post_rst_vs2");
        vec(3,   S_RGB, 6'h30, "post_rst_px0_0");
        vec(658, S_HS,  6'h1,  "post_rst_hs_before");
        vec(659, S_HS,  6'h0,  "post_rst_hs_fall");
        vec(4 * LINE + 4 + 3, S_RGB, 6'h0C, "post_rst_px4_4");

        check("ft_count", 32'(ft_cnt), 32'd2);
        check("ft_first_cyc", 32'(ft_cyc[0]), 32'(VA * LINE + 1));
        check("ft_period", 32'(ft_cyc[1] - ft_cyc[0]), 32'(FRAME));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
